// File: rtl/gate_selftest_pkg.sv
// Shared types and truth table for the gate block self-test sequencer.
package gate_selftest_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int NUM_VEC = 4;

    // Expected {Nand,And,Or,Nor} per vector {InputUp,InputBottom}.
    localparam logic [3:0] EXP [0:NUM_VEC-1] = '{4'b1001, 4'b1010, 4'b1010, 4'b0110};

    function automatic logic [3:0] exp_result(input logic [1:0] k);
        return EXP[k];
    endfunction

endpackage

// File: rtl/gate_selftest_ctrl_settle_timer.sv
// Settle-time down counter: load sets the count, enable decrements to zero.
// Latency: count visible one cycle after load; zero flag is combinational off the count.
// Backpressure: none; the counter holds at zero until reloaded.
module settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer: walks the four gate input vectors and checks outputs against the truth table.
// Latency: SETTLE_CYCLES+2 cycles per vector; done pulses 4*(SETTLE_CYCLES+2) edges after start.
// Backpressure: start is ignored while busy; abort returns to IDLE on the next edge.
module gate_selftest_ctrl
    import gate_selftest_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       OutNand,
    input  logic       OutAnd,
    input  logic       OutOr,
    input  logic       OutNor,
    output logic       InputUp,
    output logic       InputBottom,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] failMask,
    output logic [2:0] errCount,
    output logic [1:0] firstFailIdx,
    output logic [3:0] firstFailObs
);

    // The timer holds SETTLE_CYCLES-1 so the zero-cycle of SETTLE is the last wait cycle.
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [1:0] in_q, in_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic [2:0] err_cnt_q, err_cnt_d;
    logic [1:0] ff_idx_q, ff_idx_d;
    logic [3:0] ff_obs_q, ff_obs_d;

    logic       tmr_load;
    logic       tmr_en;
    logic       tmr_zero;
    logic [3:0] obs;

    assign obs = {OutNand, OutAnd, OutOr, OutNor};

    settle_timer #(
        .CNT_W(CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LOAD),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        in_d        = in_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        err_cnt_d   = err_cnt_q;
        ff_idx_d    = ff_idx_q;
        ff_obs_d    = ff_obs_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;

        if (abort) begin
            state_d = IDLE;
            in_d    = 2'b00;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_d = 2'b00;
                    if (start) begin
                        fail_mask_d = '0;
                        err_cnt_d   = '0;
                        ff_idx_d    = '0;
                        ff_obs_d    = '0;
                        pass_d      = 1'b0;
                        vec_d       = 2'd0;
                        state_d     = APPLY;
                    end
                end
                APPLY: begin
                    in_d     = vec_q;
                    tmr_load = 1'b1;
                    state_d  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    tmr_en = 1'b1;
                    if (tmr_zero) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (obs != exp_result(vec_q)) begin
                        fail_mask_d[vec_q] = 1'b1;
                        err_cnt_d          = err_cnt_q + 3'd1;
                        if (err_cnt_q == '0) begin
                            ff_idx_d = vec_q;
                            ff_obs_d = obs;
                        end
                    end
                    if (vec_q == 2'(NUM_VEC - 1)) begin
                        // pass is settled here so it is already valid alongside done.
                        pass_d  = (err_cnt_d == '0);
                        state_d = DONE;
                    end else begin
                        vec_d   = vec_q + 2'd1;
                        state_d = APPLY;
                    end
                end
                DONE: begin
                    in_d    = 2'b00;
                    state_d = IDLE;
                end
                default: begin
                    in_d    = 2'b00;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            in_q        <= '0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            err_cnt_q   <= '0;
            ff_idx_q    <= '0;
            ff_obs_q    <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            in_q        <= in_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            err_cnt_q   <= err_cnt_d;
            ff_idx_q    <= ff_idx_d;
            ff_obs_q    <= ff_obs_d;
        end
    end

    assign InputUp      = in_q[1];
    assign InputBottom  = in_q[0];
    assign busy         = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
    assign done         = (state_q == DONE);
    assign pass         = pass_q;
    assign failMask     = fail_mask_q;
    assign errCount     = err_cnt_q;
    assign firstFailIdx = ff_idx_q;
    assign firstFailObs = ff_obs_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Directed bench for gate_selftest_ctrl: gate models (good, Or stuck-at-0, 1-cycle delayed), abort and reset.
module tb_gate_selftest_ctrl;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    int   mode;  // 0 good gate, 1 OutOr stuck at 0, 2 outputs delayed one cycle

    always #5 clk = ~clk;

    // Instance with default settle time
    logic       up_a, bot_a, busy_a, done_a, pass_a;
    logic [3:0] mask_a, fobs_a, obs_a, dly_a;
    logic [2:0] err_a;
    logic [1:0] fidx_a;

    // Instance with zero settle time
    logic       up_z, bot_z, busy_z, done_z, pass_z;
    logic [3:0] mask_z, fobs_z, obs_z, dly_z;
    logic [2:0] err_z;
    logic [1:0] fidx_z;

    function automatic logic [3:0] gate(input logic [1:0] ab);
        logic a, b;
        a = ab[1];
        b = ab[0];
        return {~(a & b), a & b, a | b, ~(a | b)};
    endfunction

    always @(posedge clk) begin
        dly_a <= gate({up_a, bot_a});
        dly_z <= gate({up_z, bot_z});
    end

    assign obs_a = (mode == 0) ? gate({up_a, bot_a}) :
                   (mode == 1) ? (gate({up_a, bot_a}) & 4'b1101) : dly_a;
    assign obs_z = (mode == 0) ? gate({up_z, bot_z}) :
                   (mode == 1) ? (gate({up_z, bot_z}) & 4'b1101) : dly_z;

    gate_selftest_ctrl #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .OutNand(obs_a[3]), .OutAnd(obs_a[2]), .OutOr(obs_a[1]), .OutNor(obs_a[0]),
        .InputUp(up_a), .InputBottom(bot_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .failMask(mask_a), .errCount(err_a), .firstFailIdx(fidx_a), .firstFailObs(fobs_a)
    );

    gate_selftest_ctrl #(.SETTLE_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .OutNand(obs_z[3]), .OutAnd(obs_z[2]), .OutOr(obs_z[1]), .OutNor(obs_z[0]),
        .InputUp(up_z), .InputBottom(bot_z), .busy(busy_z), .done(done_z), .pass(pass_z),
        .failMask(mask_z), .errCount(err_z), .firstFailIdx(fidx_z), .firstFailObs(fobs_z)
    );

    int          checks = 0;
    int          errors = 0;
    int          done_cyc, done_cnt;
    logic        pass_at_done;
    logic [7:0]  vis;
    logic [17:0] snap;

    function automatic logic [17:0] snapshot();
        return {up_a, bot_a, busy_a, done_a, pass_a, mask_a, err_a, fidx_a, fobs_a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Start pulse at edge E0, then observe 24 edges; optional mid-run restart/abort/reset at edge n.
    task automatic run(input int restart_at, input int abort_at, input int rst_at);
        done_cyc     = -1;
        done_cnt     = 0;
        pass_at_done = 1'bx;
        vis          = 8'hxx;
        snap         = 18'h3ffff;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = n;
                    pass_at_done = pass_a;
                end
            end
            if ((n % 4 == 2) && (n <= 14)) vis[2*(n/4) +: 2] = {up_a, bot_a};
            if (n == restart_at) start = 1'b1;
            else if (n == restart_at + 1) start = 1'b0;
            if (n == abort_at) abort = 1'b1;
            if (n == abort_at + 1) begin
                snap  = snapshot();
                abort = 1'b0;
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1 snap = snapshot();
            end
            if (n == rst_at + 1) rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 32'(snapshot()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good gate: done 16 edges after start, clean results, vectors 00,01,10,11.
        mode = 0;
        run(-10, -10, -10);
        chk("good_done_cycle", done_cyc, 16);
        chk("good_done_count", done_cnt, 1);
        chk("good_pass_at_done", 32'(pass_at_done), 1);
        chk("good_fail_mask", 32'(mask_a), 0);
        chk("good_err_count", 32'(err_a), 0);
        chk("good_vector_order", 32'(vis), 32'hE4);

        // OutOr stuck at 0 fails vectors 1,2,3.
        mode = 1;
        run(-10, -10, -10);
        chk("stuck_done_cycle", done_cyc, 16);
        chk("stuck_fail_mask", 32'(mask_a), 32'b1110);
        chk("stuck_err_count", 32'(err_a), 3);
        chk("stuck_first_idx", 32'(fidx_a), 1);
        chk("stuck_first_obs", 32'(fobs_a), 32'b1000);
        chk("stuck_pass", 32'(pass_a), 0);

        // One-cycle delayed gate: settle 2 hides it, settle 0 sees the previous vector's result.
        mode = 2;
        run(-10, -10, -10);
        chk("delay_s2_pass", 32'(pass_a), 1);
        chk("delay_s2_fail_mask", 32'(mask_a), 0);
        chk("delay_s0_fail_mask", 32'(mask_z), 32'b1010);
        chk("delay_s0_err_count", 32'(err_z), 2);
        chk("delay_s0_first_idx", 32'(fidx_z), 1);
        chk("delay_s0_first_obs", 32'(fobs_z), 32'b1001);
        chk("delay_s0_pass", 32'(pass_z), 0);

        // Start pulse at E0+5 is ignored.
        mode = 0;
        run(5, -10, -10);
        chk("restart_done_cycle", done_cyc, 16);
        chk("restart_done_count", done_cnt, 1);
        chk("restart_pass", 32'(pass_a), 1);

        // Abort in SETTLE of vector 2 with Or stuck: partial results kept.
        mode = 1;
        run(-10, 9, -10);
        chk("abort_in_busy_done_pass", 32'(snap[17:13]), 0);
        chk("abort_done_count", done_cnt, 0);
        chk("abort_fail_mask", 32'(mask_a), 32'b0010);
        chk("abort_err_count", 32'(err_a), 1);
        chk("abort_pass", 32'(pass_a), 0);

        // Reset asserted in CHECK of vector 2 clears everything at once.
        mode = 1;
        run(-10, -10, 11);
        chk("reset_midrun_outputs", 32'(snap), 0);
        chk("reset_midrun_done_count", done_cnt, 0);

        mode = 0;
        run(-10, -10, -10);
        chk("post_reset_done_cycle", done_cyc, 16);
        chk("post_reset_pass", 32'(pass_a), 1);
        chk("post_reset_fail_mask", 32'(mask_a), 0);
        chk("post_reset_vector_order", 32'(vis), 32'hE4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_selftest_ctrl.md
# gate_selftest_ctrl

Self-test sequencer for the two-input gate block (InputUp/InputBottom → OutNand/OutAnd/OutOr/OutNor). On a start request it drives all four input combinations into the gate block, waits a programmable settle time per vector, and compares the four outputs against the truth table. It then reports pass/fail, a per-vector fail mask, an error count and the first failing capture. It sits between the gate block and the board-level control/status logic and is the only driver of the gate inputs.

## Interface
- SETTLE_CYCLES, 2, wait cycles between applying a vector and sampling outputs; 0 is legal.
- CNT_W, 8, settle counter width; SETTLE_CYCLES < 2^CNT_W.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled in IDLE only.
- abort  input  1  synchronous abort, effective in any state.
- OutNand, OutAnd, OutOr, OutNor  input  1 each  gate block outputs under test.
- InputUp, InputBottom  output  1 each  registered drive to the gate block.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse at the end of a completed run.
- pass  output  1  sticky: 1 when the last completed run had zero errors.
- failMask  output  4  bit k = vector k failed (k = {InputUp,InputBottom}).
- errCount  output  3  number of failing vectors, 0..4.
- firstFailIdx  output  2  index of the first failing vector.
- firstFailObs  output  4  observed {OutNand,OutAnd,OutOr,OutNor} for that vector.

## Operation
- States: IDLE → APPLY → SETTLE → CHECK → (APPLY for next vector | DONE) → IDLE.
- Vector order k = 0,1,2,3 as {InputUp,InputBottom} = 00,01,10,11.
- Expected {Nand,And,Or,Nor}: 00→1001, 01→1010, 10→1010, 11→0110.
- IDLE: InputUp/InputBottom = 0. When start=1, clear failMask, errCount, firstFail* and pass, then go to APPLY with k=0.
- APPLY (1 cycle): register vector k onto InputUp/InputBottom, load the settle counter.
- SETTLE: SETTLE_CYCLES cycles. Skipped entirely when SETTLE_CYCLES=0.
- CHECK (1 cycle): compare the sampled outputs with the expected value. On mismatch, set failMask[k] and increment errCount. If this is the first failure, capture k and the observed outputs. Then go to APPLY with k+1, or to DONE after k=3.
- DONE (1 cycle): done=1, pass=(errCount==0), busy=0. Go to IDLE. Results hold until the next accepted start.
- start while busy: ignored; no restart or queueing.
- abort=1: return to IDLE on the next edge and drive inputs to 0. No done pulse. pass=0. failMask/errCount keep their partial values. abort has priority over start in the same cycle.
- rst_n low mid-run: all state and outputs return to reset values immediately.

## Timing
- Reset values: state IDLE; InputUp, InputBottom, busy, done and pass = 0; failMask, errCount, firstFailIdx and firstFailObs = 0.
- Edge E0 with start=1 in IDLE: busy=1 and APPLY k=0 after E0.
- Per-vector cost: SETTLE_CYCLES+2 cycles.
- done is high in the cycle following edge E0 + 4·(SETTLE_CYCLES+2); with the default, that is 16 edges after E0.
- Output sampling: outputs are registered in CHECK, at least SETTLE_CYCLES+1 edges after the inputs change.
- Back-to-back runs: start may be asserted in the IDLE cycle right after DONE; the minimum run-to-run gap is 1 cycle.

## Structure
- Package gate_selftest_pkg:
  - state enum (IDLE, APPLY, SETTLE, CHECK, DONE);
  - vector count constant NUM_VEC=4;
  - expected-result table EXP[0:3] = {4'b1001, 4'b1010, 4'b1010, 4'b0110}.
- Sub-module settle_timer (CNT_W-bit down counter: load, enable, zero flag) instantiated once. Everything else lives in the top FSM.

## Test plan
- Correct gate model, SETTLE_CYCLES=2, pulse start → done at E0+16, pass=1, failMask=0000, errCount=0; InputUp/InputBottom visit 00,01,10,11.
- Faulty model (OutOr stuck at 0) → failMask=1110, errCount=3, firstFailIdx=1, firstFailObs=1000, pass=0.
- Model with 1-cycle output delay and SETTLE_CYCLES=0 → failures appear. The same model with SETTLE_CYCLES=2 → pass=1.
- Pulse start again at E0+5 mid-run → ignored; done still at E0+16, exactly one done pulse.
- abort during SETTLE of vector 2 → IDLE next cycle, busy=0, no done, InputUp=InputBottom=0, pass=0.
- rst_n low during CHECK → all outputs 0 immediately. A later start runs a full clean sequence.
